song_sequencer: RTL and testbench
=================================

# song_sequencer

Hardware playback controller for the audio path. The CPU programs a song start address and note count through memory-mapped writes; the block then fetches note words from data RAM through a request/grant port and drives the PWM serializer's duty cycle for each note's duration. The CPU can do other work during playback. The block sits between the processor's MMIO decode, the data-RAM arbiter (CPU has priority) and the PWM audio serializer.

## Interface
- `ADDR_W`, 12, RAM word-address width.
- `DUTY_W`, 10, duty-cycle width fed to the PWM serializer.
- `TICK_DIV`, 50000, clock cycles per duration tick (1 ms at 50 MHz).
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `cfg_we`  in  1  MMIO write strobe for this block.
- `cfg_addr`  in  2  register select: 0 = START_ADDR, 1 = LENGTH, 2 = CTRL.
- `cfg_wdata`  in  32  MMIO write data.
- `mem_req`  out  1  RAM read request.
- `mem_addr`  out  ADDR_W  RAM word address; stable while `mem_req` is high.
- `mem_gnt`  in  1  arbiter grant for the current cycle.
- `mem_rdata`  in  32  RAM data, valid the cycle after `mem_gnt`.
- `duty_cycle`  out  DUTY_W  to PWM serializer.
- `audio_enable`  out  1  high only while in PLAY with nonzero duty.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at natural end of song.
- `note_index`  out  ADDR_W  index of the note being fetched or played.

## Operation
- Registers: START_ADDR (`cfg_wdata[ADDR_W-1:0]`), LENGTH (`cfg_wdata[ADDR_W-1:0]`), CTRL (bit0 START, bit1 STOP, bit2 LOOP). START and STOP are self-clearing strobes. LOOP is sticky.
- START_ADDR and LENGTH are copied into working registers on START. Later writes only affect the next START.
- Note word format:
  - [9:0]: duty; 0 means a rest.
  - [25:10]: duration in ticks.
  - [31:26]: ignored.
  - A duration of 0 is a terminator and ends the song.
- FSM states: IDLE, FETCH, WAIT, PLAY.
  - IDLE → FETCH on START with LENGTH ≠ 0. `note_index` ← 0.
  - FETCH: `mem_req` = 1, `mem_addr` = (start + `note_index`) mod 2^ADDR_W. Stays in FETCH until `mem_gnt` = 1, then goes to WAIT.
  - WAIT: latch `mem_rdata`.
    - If duration = 0: end of song.
    - Otherwise: load `duty_cycle` and the duration counter, clear the prescaler, go to PLAY.
  - PLAY: the prescaler counts 0..TICK_DIV-1, giving a tick at the wrap. Each tick decrements the duration counter. When the counter reaches 0:
    - If `note_index` = LENGTH-1: end of song.
    - Otherwise: `note_index`++, go to FETCH.
  - End of song:
    - If LOOP is set: `note_index` ← 0, go to FETCH. No `done` pulse.
    - Otherwise: `done` pulse, `duty_cycle` ← 0, go to IDLE.
- `duty_cycle` holds the previous note's value through FETCH and WAIT. `audio_enable` drops during FETCH and WAIT.

## Timing
- Reset values: IDLE; `mem_req` 0, `mem_addr` 0, `duty_cycle` 0, `audio_enable` 0, `busy` 0, `done` 0, `note_index` 0; LOOP 0.
- `cfg_we` with START at cycle N: `mem_req` rises at N+1.
- Grant at cycle G: WAIT at G+1, PLAY and the new `duty_cycle` at G+2.
- A note of duration D occupies exactly D·TICK_DIV cycles in PLAY.
- Boundary conditions:
  - START with LENGTH = 0: no state change; `done` pulses at N+1.
  - STOP (any state): next cycle IDLE, `mem_req` 0, `duty_cycle` 0, no `done`. Any in-flight `mem_rdata` is discarded.
  - START and STOP in the same write: STOP wins.
  - START while busy: restart from the new START_ADDR at note 0, same timing as from IDLE.
  - Address wraps modulo 2^ADDR_W.
  - `mem_gnt` low indefinitely: the block waits in FETCH; `mem_addr` stays stable.
  - `reset` mid-operation: all state returns to the reset values on the next edge.

## Configuration
- `SONG_SEQ_LOOP_EN` defined: CTRL bit2 implemented, with loop behaviour as described above.
- Undefined: LOOP register removed and bit2 ignored; end of song always pulses `done` and returns to IDLE.

## Test plan
- TICK_DIV=4, START_ADDR=0x100, LENGTH=2, notes {duty 300, dur 3}, {duty 0, dur 1}:
  - `duty_cycle` = 300 for 12 cycles, then 0 for 4 cycles.
  - `done` pulses once; `busy` ends low.
- `mem_gnt` held low for 10 cycles in FETCH → `mem_req` and `mem_addr` (0x100) stable for all 10 cycles; playback proceeds after the grant.
- Terminator word at note 1 with LENGTH=5 → `done` after note 0; only 2 fetches issued.
- STOP written mid-PLAY of a 500-duty note → next cycle `duty_cycle` = 0, `busy` = 0, no `done` pulse.
- START_ADDR=0xFFF, LENGTH=2 → fetch addresses 0xFFF then 0x000.
- `SONG_SEQ_LOOP_EN` with LOOP=1, LENGTH=1 → note refetched from START_ADDR repeatedly, no `done`; STOP then ends playback.

Source files
------------

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : song_sequencer
// Description : Hardware song playback controller. The CPU programs a start
//               address and a note count over MMIO. The block then fetches
//               note words from data RAM through a request/grant port and
//               drives the PWM serializer duty cycle for each note duration.
//               Optional feature macro: SONG_SEQ_LOOP_EN (CTRL bit2 LOOP).
// Revision    : 1.0 - initial release
// ============================================================================
module song_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int DUTY_W   = 10,
    parameter int TICK_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [31:0]       mem_rdata,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              audio_enable,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_index
);

    // Register map and field geometry
    localparam logic [1:0] c_reg_start_addr = 2'd0;
    localparam logic [1:0] c_reg_length     = 2'd1;
    localparam logic [1:0] c_reg_ctrl       = 2'd2;
    localparam int         c_dur_w          = 16;
    // A divider of 1 still needs a one-bit prescaler that always wraps
    localparam int                   c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    // Programming registers (shadow copies, only sampled on START)
    logic [ADDR_W-1:0]    r_start_cfg;
    logic [ADDR_W-1:0]    r_length_cfg;

    // Working state
    state_t               r_state;
    logic [ADDR_W-1:0]    r_start;
    logic [ADDR_W-1:0]    r_length;
    logic [ADDR_W-1:0]    r_note_index;
    logic [c_dur_w-1:0]   r_dur;
    logic [c_presc_w-1:0] r_presc;

    // Registered outputs
    logic                 r_mem_req;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DUTY_W-1:0]    r_duty;
    logic                 r_audio_en;
    logic                 r_busy;
    logic                 r_done;

    // Decoded control and datapath helpers
    logic                 w_ctrl_wr;
    logic                 w_start_cmd;
    logic                 w_stop_cmd;
    logic                 w_loop;
    logic [DUTY_W-1:0]    w_note_duty;
    logic [c_dur_w-1:0]   w_note_dur;
    logic                 w_tick;
    logic                 w_note_over;
    logic                 w_last_note;
    logic                 w_song_end;
    logic [ADDR_W-1:0]    w_next_addr;
    logic                 w_unused;

    assign w_ctrl_wr   = cfg_we && (cfg_addr == c_reg_ctrl);
    assign w_start_cmd = w_ctrl_wr && cfg_wdata[0];
    assign w_stop_cmd  = w_ctrl_wr && cfg_wdata[1];

    // Note word: [9:0] duty, [25:10] duration in ticks, [31:26] ignored
    assign w_note_duty = DUTY_W'(mem_rdata[9:0]);
    assign w_note_dur  = mem_rdata[25:10];

    assign w_tick      = (r_presc == c_presc_max);
    // Last tick of the current note: the duration counter is about to hit 0
    assign w_note_over = (r_state == ST_PLAY) && w_tick && (r_dur == c_dur_w'(1));
    assign w_last_note = (r_note_index == (r_length - ADDR_W'(1)));
    // Song ends on a terminator word or after the final note of LENGTH
    assign w_song_end  = ((r_state == ST_WAIT) && (w_note_dur == '0)) ||
                         (w_note_over && w_last_note);
    // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W address wrap
    assign w_next_addr = r_start + r_note_index + ADDR_W'(1);

    // Upper data bits and the note word's ignored field are intentionally unused
    assign w_unused = ^{cfg_wdata, mem_rdata};

    // Capture START_ADDR and LENGTH writes for the next START
    always_ff @(posedge clock) begin
        if (reset) begin
            r_start_cfg  <= '0;
            r_length_cfg <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == c_reg_start_addr) begin
                r_start_cfg <= cfg_wdata[ADDR_W-1:0];
            end
            if (cfg_addr == c_reg_length) begin
                r_length_cfg <= cfg_wdata[ADDR_W-1:0];
            end
        end
    end

`ifdef SONG_SEQ_LOOP_EN
    logic r_loop;

    // LOOP is sticky: it follows CTRL bit2 on every CTRL write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_loop <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_loop <= cfg_wdata[2];
        end
    end

    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    // Playback FSM: STOP beats START, START restarts from any state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_start      <= '0;
            r_length     <= '0;
            r_note_index <= '0;
            r_dur        <= '0;
            r_presc      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_duty       <= '0;
            r_audio_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_stop_cmd) begin
                // Abort: any read data still in flight is simply never latched
                r_state    <= ST_IDLE;
                r_mem_req  <= 1'b0;
                r_duty     <= '0;
                r_audio_en <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_start_cmd) begin
                if (r_length_cfg == '0) begin
                    // Empty song: report completion without touching playback
                    r_done <= 1'b1;
                end else begin
                    r_state      <= ST_FETCH;
                    r_start      <= r_start_cfg;
                    r_length     <= r_length_cfg;
                    r_note_index <= '0;
                    r_mem_req    <= 1'b1;
                    r_mem_addr   <= r_start_cfg;
                    r_audio_en   <= 1'b0;
                    r_busy       <= 1'b1;
                end
            end else if (w_song_end) begin
                r_audio_en <= 1'b0;
                if (w_loop) begin
                    r_state      <= ST_FETCH;
                    r_note_index <= '0;
                    r_mem_req    <= 1'b1;
                    r_mem_addr   <= r_start;
                end else begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    r_duty  <= '0;
                    r_busy  <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        // Address is held until the arbiter grants the read
                        if (mem_gnt) begin
                            r_state   <= ST_WAIT;
                            r_mem_req <= 1'b0;
                        end
                    end
                    ST_WAIT: begin
                        // Non-terminator note: the terminator case is w_song_end
                        r_duty     <= w_note_duty;
                        r_dur      <= w_note_dur;
                        r_presc    <= '0;
                        r_audio_en <= (w_note_duty != '0);
                        r_state    <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        r_presc <= w_tick ? '0 : (r_presc + c_presc_w'(1));
                        if (w_tick) begin
                            r_dur <= r_dur - c_dur_w'(1);
                        end
                        if (w_note_over) begin
                            r_audio_en   <= 1'b0;
                            r_note_index <= r_note_index + ADDR_W'(1);
                            r_mem_addr   <= w_next_addr;
                            r_mem_req    <= 1'b1;
                            r_state      <= ST_FETCH;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign duty_cycle   = r_duty;
    assign audio_enable = r_audio_en;
    assign busy         = r_busy;
    assign done         = r_done;
    assign note_index   = r_note_index;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_song_sequencer
// Description : Scoreboard bench for song_sequencer. A song model expands
//               RAM contents into fetch / note / done events; a monitor
//               reconstructs the same events from the DUT pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

    localparam int ADDR_W = 12;
    localparam int DUTY_W = 10;
    localparam int TICK   = 4;
    localparam int K_FETCH = 0;
    localparam int K_PLAY  = 1;
    localparam int K_DONE  = 2;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [31:0]       mem_rdata;
    logic [DUTY_W-1:0] duty_cycle;
    logic              audio_enable;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_index;

    ev_t         exp_q[$];
    logic [31:0] mem [0:4095];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    int          gnt_block = 0;

    song_sequencer #(
        .ADDR_W  (ADDR_W),
        .DUTY_W  (DUTY_W),
        .TICK_DIV(TICK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rdata   (mem_rdata),
        .duty_cycle  (duty_cycle),
        .audio_enable(audio_enable),
        .busy        (busy),
        .done        (done),
        .note_index  (note_index)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] note(input int duty, input int dur);
        logic [5:0] junk;
        junk = 6'($urandom);
        return {junk, 16'(dur), 10'(duty)};
    endfunction

    task automatic push_ev(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    // Reference model: walk the song as the CPU would describe it
    task automatic push_song(input int start, input int len, input int reps, input bit with_done);
        int          addr;
        int          dur;
        logic [31:0] w;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < len; i++) begin
                addr = (start + i) % 4096;
                w    = mem[addr];
                dur  = int'(w[25:10]);
                push_ev(K_FETCH, addr, 0);
                if (dur == 0) break;
                push_ev(K_PLAY, int'(w[9:0]), dur * TICK);
            end
        end
        if (with_done) push_ev(K_DONE, 0, 0);
    endtask

    task automatic observe(input int kind, input int a, input int b, input bit ok);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, expected no event", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || !ok) begin
                n_fail++;
                $display("FAIL event: got kind=%0d a=%0d b=%0d steady=%0d, expected kind=%0d a=%0d b=%0d steady=1",
                         kind, a, b, ok, e.kind, e.a, e.b);
            end
        end
    endtask

    // Monitor: rebuild fetch / note / done events from the pins
    int phase   = 0;
    int seg_cnt = 0;
    int seg_duty = 0;
    bit seg_ok  = 1'b1;
    always @(negedge clock) begin
        if (!mon_en || reset) begin
            phase = 0;
        end else begin
            if (phase == 3) begin
                if (mem_req || !busy) begin
                    observe(K_PLAY, seg_duty, seg_cnt, seg_ok);
                    phase = 0;
                end else begin
                    seg_cnt++;
                    if (int'(duty_cycle) != seg_duty || audio_enable != (seg_duty != 0)) seg_ok = 1'b0;
                end
            end
            if (phase == 2) begin
                if (busy && !mem_req && !done) begin
                    phase    = 3;
                    seg_duty = int'(duty_cycle);
                    seg_cnt  = 1;
                    seg_ok   = (audio_enable == (duty_cycle != 0));
                end else begin
                    phase = 0;
                end
            end
            if (phase == 1) phase = 2;
            if (mem_req && mem_gnt) begin
                observe(K_FETCH, int'(mem_addr), 0, 1'b1);
                phase = 1;
            end
            if (done) observe(K_DONE, 0, 0, 1'b1);
        end
    end

    // RAM and arbiter model: random grants, data one cycle after grant
    bit pend = 1'b0;
    int pend_addr = 0;
    initial begin
        mem_gnt   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_rdata = pend ? mem[pend_addr] : $urandom;
            pend = 1'b0;
            if (gnt_block > 0) begin
                mem_gnt = 1'b0;
                gnt_block--;
            end else begin
                mem_gnt = mem_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            end
            if (mem_gnt && mem_req) begin
                pend      = 1'b1;
                pend_addr = int'(mem_addr);
            end
        end
    end

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clock);
        #1;
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clock);
        #1;
        cfg_we    = 1'b0;
        cfg_wdata = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge clock);
            cyc++;
        end
        @(negedge clock);
        if (cyc >= 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d, expected idle", name, busy, exp_q.size());
            mon_en = 1'b0;
            exp_q.delete();
            cfg_write(2'd2, 32'h2);
            @(negedge clock);
            mon_en = 1'b1;
        end
    endtask

    task automatic wait_playing(input int duty, input string name);
        int cyc;
        cyc = 0;
        while (!(audio_enable && int'(duty_cycle) == duty) && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        check(name, int'(cyc < 300), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  start;
        int  len;
        int  dur;
        int  duty;
        bit  flag;
        reset     = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_addr", int'(mem_addr), 0);
        check("reset_duty", int'(duty_cycle), 0);
        check("reset_audio_enable", audio_enable, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_note_index", int'(note_index), 0);
        mon_en = 1'b1;

        // Basic two-note song with a rest
        mem[12'h100] = note(300, 3);
        mem[12'h101] = note(0, 1);
        cfg_write(2'd0, 32'h100);
        cfg_write(2'd1, 32'd2);
        push_song(12'h100, 2, 1, 1'b1);
        cfg_write(2'd2, 32'h1);
        check("start_req_latency", mem_req, 1);
        wait_idle("basic");
        check("basic_busy_end", busy, 0);

        // Grant withheld for 10 cycles in FETCH
        @(negedge clock);
        gnt_block = 1000;
        push_song(12'h100, 2, 1, 1'b1);
        cfg_write(2'd2, 32'h1);
        flag = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (!mem_req || mem_addr != 12'h100) flag = 1'b0;
        end
        check("fetch_stall_stable", int'(flag), 1);
        gnt_block = 0;
        wait_idle("stall");

        // Terminator at note 1 of a 5-note song
        mem[12'h200] = note(700, 2);
        mem[12'h201] = note(55, 0);
        cfg_write(2'd0, 32'h200);
        cfg_write(2'd1, 32'd5);
        push_song(12'h200, 5, 1, 1'b1);
        cfg_write(2'd2, 32'h1);
        wait_idle("terminator");

        // Address wrap from 0xFFF to 0x000
        mem[12'hFFF] = note(12, 1);
        mem[12'h000] = note(1023, 2);
        cfg_write(2'd0, 32'hFFF);
        cfg_write(2'd1, 32'd2);
        push_song(12'hFFF, 2, 1, 1'b1);
        cfg_write(2'd2, 32'h1);
        wait_idle("wrap");

        // START with LENGTH = 0 only pulses done
        cfg_write(2'd1, 32'd0);
        push_ev(K_DONE, 0, 0);
        cfg_write(2'd2, 32'h1);
        check("len0_done_pulse", done, 1);
        check("len0_busy", busy, 0);
        check("len0_mem_req", mem_req, 0);
        wait_idle("len0");

        // STOP in the middle of a long note
        @(negedge clock);
        mon_en = 1'b0;
        mem[12'h300] = note(500, 10);
        cfg_write(2'd0, 32'h300);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'h1);
        wait_playing(500, "stop_reach_play");
        repeat (5) @(negedge clock);
        cfg_write(2'd2, 32'h2);
        check("stop_duty", int'(duty_cycle), 0);
        check("stop_busy", busy, 0);
        check("stop_audio_enable", audio_enable, 0);
        check("stop_mem_req", mem_req, 0);
        flag = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (done) flag = 1'b1;
        end
        check("stop_no_done", int'(flag), 0);

        // START and STOP in one write: STOP wins
        cfg_write(2'd2, 32'h1);
        wait_playing(500, "startstop_reach_play");
        cfg_write(2'd2, 32'h3);
        check("startstop_busy", busy, 0);
        check("startstop_mem_req", mem_req, 0);

        // START while busy restarts from the new START_ADDR
        cfg_write(2'd2, 32'h1);
        wait_playing(500, "restart_reach_play");
        cfg_write(2'd0, 32'h200);
        cfg_write(2'd1, 32'd5);
        exp_q.delete();
        push_song(12'h200, 5, 1, 1'b1);
        cfg_write(2'd2, 32'h1);
        check("restart_mem_req", mem_req, 1);
        check("restart_mem_addr", int'(mem_addr), 12'h200);
        check("restart_note_index", int'(note_index), 0);
        mon_en = 1'b1;
        wait_idle("restart");

        // Reset in the middle of playback
        @(negedge clock);
        mon_en = 1'b0;
        cfg_write(2'd0, 32'h300);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'h1);
        wait_playing(500, "midreset_reach_play");
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("midreset_duty", int'(duty_cycle), 0);
        check("midreset_busy", busy, 0);
        check("midreset_mem_req", mem_req, 0);
        check("midreset_mem_addr", int'(mem_addr), 0);
        check("midreset_audio_enable", audio_enable, 0);
        @(negedge clock);
        mon_en = 1'b1;

`ifdef SONG_SEQ_LOOP_EN
        // LOOP with a single note refetches it until STOP
        mem[12'h400] = note(77, 2);
        cfg_write(2'd0, 32'h400);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'h4);
        push_song(12'h400, 1, 3, 1'b0);
        push_ev(K_FETCH, 12'h400, 0);
        cfg_write(2'd2, 32'h5);
        begin
            int cyc;
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 2000) begin
                @(negedge clock);
                cyc++;
            end
            check("loop_iterations", int'(cyc < 2000), 1);
        end
        @(negedge clock);
        mon_en = 1'b0;
        cfg_write(2'd2, 32'h2);
        check("loop_stop_busy", busy, 0);
        check("loop_stop_duty", int'(duty_cycle), 0);
        exp_q.delete();
        @(negedge clock);
        mon_en = 1'b1;
`endif

        // Randomized songs
        for (int s = 0; s < 25; s++) begin
            start = ($urandom_range(0, 3) == 0) ? (4095 - $urandom_range(0, 3)) : $urandom_range(0, 4095);
            len   = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                dur  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
                duty = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 1023);
                mem[(start + i) % 4096] = note(duty, dur);
            end
            cfg_write(2'd0, 32'(start));
            cfg_write(2'd1, 32'(len));
            push_song(start, len, 1, 1'b1);
            cfg_write(2'd2, 32'h1);
            wait_idle("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
